nf_reg_wr_arb: RTL and testbench
================================

# nf_reg_wr_arb

Write-port controller for the 32 x 32-bit register file. Owns the single write port (wa3/wd3/we3): after reset it sequentially clears registers 1..31, then arbitrates between pipeline writeback, load-data returns from the load/store unit and, optionally, a debug write port. It also keeps a pending-load scoreboard that the hazard unit uses to stall reads of registers awaiting load data.

## Interface
- REG_NUM, 32: number of registers; the address width is 5 bits.
- STARVE_LIM, 4: consecutive cycles a load return may wait before `stall` is raised (1..15).
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_busy  out  1  high while the clear sequence runs; the pipeline is held
- wb_valid  in  1  pipeline writeback request; it has no ready and is never back-pressured
- wb_rd / wb_data  in  5 / 32  writeback address and data
- lsu_valid / lsu_ready  in / out  1 / 1  load-return handshake
- lsu_rd / lsu_data  in  5 / 32  load-return address and data
- lsu_iss_valid / lsu_iss_rd  in  1 / 5  a load was issued to rd; sets the pending bit
- dbg_valid / dbg_ready / dbg_rd / dbg_data  in / out / in / in  1 / 1 / 5 / 32  debug write (NF_DBG_WR_EN only)
- stall  out  1  request to the pipeline to stop issuing writebacks
- pend_vec  out  32  pending-load bitmap; bit 0 is always 0
- wa3 / wd3 / we3  out  5 / 32 / 1  register file write port

## Operation
- The FSM has two states, INIT and RUN. `rst` forces INIT, with the counter at 1, the starve counter at 0, `pend_vec` at 0 and `stall` at 0.
- **INIT:** each cycle writes 0 to register `cnt`, then `cnt` increments. After the write of register 31, the FSM moves to RUN.
  - `init_busy` is 1 throughout INIT.
  - `lsu_ready` and `dbg_ready` are 0; `wb_valid` is ignored.
  - `lsu_iss_valid` is ignored.
- **RUN priority:** stalled LSU > wb > LSU > dbg. Exactly one source is granted per cycle.
  - `lsu_ready` = RUN & (stall | !wb_valid).
  - `dbg_ready` = RUN & !wb_valid & !lsu_valid & !stall.
- **Write to rd = 0:** the handshake completes, but the registered write outputs show `we3` = 0 and `wa3` = 0.
- **Idle port:** when there is no write, `wa3` = 0 and `wd3` = 0. This is mandatory because the register file bypasses `wd3` whenever `ra == wa3`, regardless of `we3`.
- **Starve counter:** increments each RUN cycle in which `lsu_valid` & !`lsu_ready`, saturating at STARVE_LIM. It clears on LSU acceptance.
  - `stall` is set on the edge at which the counter reaches STARVE_LIM.
  - `stall` clears on the edge of the next LSU acceptance.
  - The pipeline guarantees `wb_valid` = 0 while `stall` = 1. If `wb_valid` is asserted anyway, it is dropped.
- **Scoreboard:**
  - `lsu_iss_valid` with rd != 0 sets `pend_vec[rd]`.
  - LSU acceptance clears `pend_vec[lsu_rd]`.
  - If a set and a clear hit the same index on the same edge, the set wins.

## Timing
- The write port is registered: a grant in cycle N drives `we3`/`wa3`/`wd3` in cycle N+1 for exactly one cycle.
- Reset values: `we3` = 0, `wa3` = 0, `wd3` = 0, `stall` = 0, `pend_vec` = 0, `lsu_ready` = 0, `dbg_ready` = 0.
  - `init_busy` = 1 in the first cycle after `rst` deasserts.
  - The first clear write (`wa3` = 1, `we3` = 1) appears in that same cycle.
- The clear sequence occupies 31 cycles. `init_busy` falls in the cycle after `wa3` = 31 is driven.
- The ready signals are combinational from valids and state. The handshake completes on the rising edge where valid & ready are both high. Requesters hold rd/data stable until accepted.
- The pending bit clears on the acceptance edge. From the next cycle, the register file bypass supplies the data, so the hazard unit may release the stall on `pend_vec` without an extra bubble.
- `rst` asserted mid-operation (including during INIT or while stalled) restarts INIT. Any un-accepted LSU or dbg transfer is lost, and the requester must re-issue it.

## Configuration
- **NF_DBG_WR_EN** defined: the dbg ports exist and take lowest priority, as above. A debug write to a register with its pending bit set does not clear that bit.
- **NF_DBG_WR_EN** undefined: the dbg ports are absent; the arbiter has two sources only.

## Test plan
- **Reset clear:** release `rst` -> 31 consecutive cycles with `we3` = 1, `wa3` = 1..31, `wd3` = 0. Then `init_busy` = 0, `wa3` = 0, `we3` = 0.
- **Collision:** wb (rd 5, 0xAAAA0000) and LSU (rd 6, 0x12345678) are valid in the same cycle.
  - Next cycle: write of reg 5.
  - LSU is accepted one cycle later, and reg 6 is written the cycle after.
- **Starvation:** hold `wb_valid` = 1 and `lsu_valid` = 1 (rd 7).
  - `stall` rises after 4 waiting cycles.
  - The next cycle grants the LSU, and reg 7 is written.
  - `stall` drops on the acceptance edge.
- **Scoreboard:**
  - Issue a load to rd 9 -> `pend_vec[9]` = 1.
  - LSU return for rd 9 -> the bit clears on acceptance.
  - Issue to rd 9 on the same edge as a return for rd 9 -> the bit stays 1.
- **x0 write:** wb rd 0 with data 0xFFFFFFFF -> `we3` = 0 and `wa3` = 0 next cycle. `pend_vec[0]` stays 0 even after a load is issued to rd 0.
- **Mid-run reset and debug** (NF_DBG_WR_EN):
  - Assert `rst` while LSU is pending -> INIT restarts and `pend_vec` = 0.
  - Debug write to rd 3 while no other source is valid -> accepted, and reg 3 is written next cycle.

Source files
------------

// File: rtl/nf_reg_wr_arb.sv
// Register-file write-port controller: post-reset clear of x1..x31, then arbitration of
// writeback, load returns and (with NF_DBG_WR_EN) a debug port, plus a pending-load scoreboard.
module nf_reg_wr_arb #(
  parameter int REG_NUM    = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_init_busy,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic [4:0]  i_lsu_rd,
  input  logic [31:0] i_lsu_data,
  input  logic        i_lsu_iss_valid,
  input  logic [4:0]  i_lsu_iss_rd,
`ifdef NF_DBG_WR_EN
  input  logic        i_dbg_valid,
  output logic        o_dbg_ready,
  input  logic [4:0]  i_dbg_rd,
  input  logic [31:0] i_dbg_data,
`endif
  output logic        o_stall,
  output logic [31:0] o_pend_vec,
  output logic [4:0]  o_wa3,
  output logic [31:0] o_wd3,
  output logic        o_we3
);

  localparam logic [4:0] LAST_REG = 5'(REG_NUM - 1);
  localparam logic [3:0] LIM      = 4'(STARVE_LIM);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_starve, w_starve_nxt;
  logic        r_stall, w_stall_nxt;
  logic [31:0] r_pend, w_pend_nxt;
  logic        r_busy;
  logic        r_we3;
  logic [4:0]  r_wa3;
  logic [31:0] r_wd3;

  logic        w_lsu_ready, w_lsu_acc;
  logic        w_dbg_ready, w_dbg_acc;
  logic        w_dbg_valid;
  logic [4:0]  w_dbg_rd;
  logic [31:0] w_dbg_data;
  logic        w_grant, w_we;
  logic [4:0]  w_rd, w_wa;
  logic [31:0] w_data, w_wd;

`ifdef NF_DBG_WR_EN
  assign w_dbg_valid = i_dbg_valid;
  assign w_dbg_rd    = i_dbg_rd;
  assign w_dbg_data  = i_dbg_data;
  assign o_dbg_ready = w_dbg_ready;
`else
  assign w_dbg_valid = 1'b0;
  assign w_dbg_rd    = 5'd0;
  assign w_dbg_data  = 32'd0;
`endif

  // Next state, handshakes and single-source write grant
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lsu_ready = 1'b0;
    w_lsu_acc   = 1'b0;
    w_dbg_ready = 1'b0;
    w_dbg_acc   = 1'b0;
    w_grant     = 1'b0;
    w_rd        = 5'd0;
    w_data      = 32'd0;
    case (r_state)
      S_INIT: begin
        w_grant   = 1'b1;
        w_rd      = r_cnt;
        w_cnt_nxt = r_cnt + 5'd1;
        if (r_cnt == LAST_REG) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_INIT;
        end
      end
      S_RUN: begin
        w_lsu_ready = r_stall | ~i_wb_valid;
        w_lsu_acc   = i_lsu_valid & w_lsu_ready;
        w_dbg_ready = ~i_wb_valid & ~i_lsu_valid & ~r_stall;
        w_dbg_acc   = w_dbg_valid & w_dbg_ready;
        // an accepted load is either the stalled one or wb is absent, so it ranks first here
        if (w_lsu_acc) begin
          w_grant = 1'b1;
          w_rd    = i_lsu_rd;
          w_data  = i_lsu_data;
        end else if (i_wb_valid && !r_stall) begin
          w_grant = 1'b1;
          w_rd    = i_wb_rd;
          w_data  = i_wb_data;
        end else if (w_dbg_acc) begin
          w_grant = 1'b1;
          w_rd    = w_dbg_rd;
          w_data  = w_dbg_data;
        end else begin
          w_grant = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  // Writes to x0 and idle cycles both present an all-zero port so the bypass sees zeros
  always_comb begin
    w_we = w_grant & (w_rd != 5'd0);
    if (w_we) begin
      w_wa = w_rd;
      w_wd = w_data;
    end else begin
      w_wa = 5'd0;
      w_wd = 32'd0;
    end
  end

  // Starvation counter and stall request
  always_comb begin
    w_starve_nxt = r_starve;
    w_stall_nxt  = r_stall;
    if (r_state == S_RUN) begin
      if (w_lsu_acc) begin
        w_starve_nxt = 4'd0;
        w_stall_nxt  = 1'b0;
      end else if (i_lsu_valid) begin
        if (r_starve < LIM) begin
          w_starve_nxt = r_starve + 4'd1;
          w_stall_nxt  = (r_starve == (LIM - 4'd1)) | r_stall;
        end else begin
          w_starve_nxt = LIM;
          w_stall_nxt  = 1'b1;
        end
      end else begin
        w_starve_nxt = r_starve;
      end
    end else begin
      w_starve_nxt = 4'd0;
      w_stall_nxt  = 1'b0;
    end
  end

  // Pending-load scoreboard; a same-edge set overrides the clear
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_lsu_acc) begin
      w_pend_nxt[i_lsu_rd] = 1'b0;
    end else begin
      w_pend_nxt = r_pend;
    end
    if ((r_state == S_RUN) && i_lsu_iss_valid && (i_lsu_iss_rd != 5'd0)) begin
      w_pend_nxt[i_lsu_iss_rd] = 1'b1;
    end else begin
      w_pend_nxt[0] = 1'b0;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_INIT;
      r_cnt    <= 5'd1;
      r_starve <= 4'd0;
      r_stall  <= 1'b0;
      r_pend   <= 32'd0;
      r_busy   <= 1'b1;
      r_we3    <= 1'b0;
      r_wa3    <= 5'd0;
      r_wd3    <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_starve_nxt;
      r_stall  <= w_stall_nxt;
      r_pend   <= w_pend_nxt;
      r_busy   <= (r_state == S_INIT);
      r_we3    <= w_we;
      r_wa3    <= w_wa;
      r_wd3    <= w_wd;
    end
  end

  assign o_init_busy = r_busy;
  assign o_lsu_ready = w_lsu_ready;
  assign o_stall     = r_stall;
  assign o_pend_vec  = r_pend;
  assign o_we3       = r_we3;
  assign o_wa3       = r_wa3;
  assign o_wd3       = r_wd3;

endmodule

// File: tb/tb_nf_reg_wr_arb.sv
// Bench for nf_reg_wr_arb: rule-level model checked every cycle plus directed literal checks.
module tb_nf_reg_wr_arb;
  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wb_valid, lsu_valid, iss_valid, dbg_valid;
  logic [4:0]  wb_rd, lsu_rd, iss_rd, dbg_rd;
  logic [31:0] wb_data, lsu_data, dbg_data;
  logic        init_busy, lsu_ready, dbg_ready, stall, we3;
  logic [31:0] pend_vec, wd3;
  logic [4:0]  wa3;

  nf_reg_wr_arb #(.REG_NUM(32), .STARVE_LIM(LIM)) dut (
    .i_clk(clk), .i_rst(rst), .o_init_busy(init_busy),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
    .i_lsu_iss_valid(iss_valid), .i_lsu_iss_rd(iss_rd),
`ifdef NF_DBG_WR_EN
    .i_dbg_valid(dbg_valid), .o_dbg_ready(dbg_ready), .i_dbg_rd(dbg_rd), .i_dbg_data(dbg_data),
`endif
    .o_stall(stall), .o_pend_vec(pend_vec), .o_wa3(wa3), .o_wd3(wd3), .o_we3(we3)
  );

`ifndef NF_DBG_WR_EN
  assign dbg_ready = 1'b0;
`endif

  typedef struct packed {
    logic        run;
    logic [5:0]  clr;
    logic        busy;
    logic [3:0]  starve;
    logic        stall;
    logic [31:0] pend;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } mdl_t;

  mdl_t m;
  bit   chk_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic mdl_t mstep(mdl_t c, logic r, logic wv, logic [4:0] wr, logic [31:0] wdt,
                                 logic lv, logic [4:0] lr, logic [31:0] ldt,
                                 logic iv, logic [4:0] ir, logic dv, logic [4:0] dr, logic [31:0] ddt);
    mdl_t        n;
    logic [3:0]  elig;
    int          src;
    logic [4:0]  rd;
    logic [31:0] dat;
    n = c;
    n.we = 1'b0; n.wa = 5'd0; n.wd = 32'd0;
    rd = 5'd0; dat = 32'd0;
    if (r) begin
      n.run = 1'b0; n.clr = 6'd1; n.busy = 1'b1; n.starve = 4'd0; n.stall = 1'b0; n.pend = 32'd0;
      return n;
    end
    n.busy = !c.run;
    if (!c.run) begin
      n.we = 1'b1; n.wa = c.clr[4:0]; n.clr = c.clr + 6'd1;
      if (c.clr == 6'd31) n.run = 1'b1;
      return n;
    end
    // priority order: stalled load, writeback, load, debug
    elig[0] = c.stall & lv;
    elig[1] = !c.stall & wv;
    elig[2] = lv;
    elig[3] = dv & !wv & !lv & !c.stall;
    src = -1;
    for (int k = 0; k < 4; k++) if (elig[k] && src < 0) src = k;
    if (src == 1) begin rd = wr; dat = wdt; end
    else if (src == 3) begin rd = dr; dat = ddt; end
    else if (src >= 0) begin rd = lr; dat = ldt; end
    if (src >= 0 && rd != 5'd0) begin n.we = 1'b1; n.wa = rd; n.wd = dat; end
    if (src == 0 || src == 2) begin
      n.starve = 4'd0; n.stall = 1'b0; n.pend[lr] = 1'b0;
    end else if (lv) begin
      if (int'(c.starve) < LIM) n.starve = c.starve + 4'd1;
      if (int'(n.starve) == LIM) n.stall = 1'b1;
    end
    if (iv && ir != 5'd0) n.pend[ir] = 1'b1;
    return n;
  endfunction

  always @(posedge clk)
    m <= mstep(m, rst, wb_valid, wb_rd, wb_data, lsu_valid, lsu_rd, lsu_data,
               iss_valid, iss_rd, dbg_valid, dbg_rd, dbg_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_we3", 32'(we3), 32'(m.we));
      chk("m_wa3", 32'(wa3), 32'(m.wa));
      chk("m_wd3", wd3, m.wd);
      chk("m_init_busy", 32'(init_busy), 32'(m.busy));
      chk("m_stall", 32'(stall), 32'(m.stall));
      chk("m_pend_vec", pend_vec, m.pend);
      chk("m_lsu_ready", 32'(lsu_ready), 32'(m.run & (m.stall | !wb_valid)));
`ifdef NF_DBG_WR_EN
      chk("m_dbg_ready", 32'(dbg_ready), 32'(m.run & !wb_valid & !lsu_valid & !m.stall));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0; dbg_valid = 1'b0;
    wb_rd = 5'd0; lsu_rd = 5'd0; iss_rd = 5'd0; dbg_rd = 5'd0;
    wb_data = 32'd0; lsu_data = 32'd0; dbg_data = 32'd0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("rst_pend", pend_vec, 32'd0);

    // clear sequence, with traffic that INIT must ignore
    rst = 1'b0;
    step(1);
    chk("init_first_wa3", 32'(wa3), 32'd1);
    chk("init_first_we3", 32'(we3), 32'd1);
    chk("init_first_busy", 32'(init_busy), 32'd1);
    wb(5'd2, 32'h2); lsu(5'd3, 32'h3); iss(5'd4);
    step(3);
    idle();
    step(27);
    chk("init_last_wa3", 32'(wa3), 32'd31);
    chk("init_last_busy", 32'(init_busy), 32'd1);
    chk("init_last_wd3", wd3, 32'd0);
    step(1);
    chk("run_busy", 32'(init_busy), 32'd0);
    chk("run_idle_we3", 32'(we3), 32'd0);
    chk("run_idle_wa3", 32'(wa3), 32'd0);
    chk("run_pend_ignored", pend_vec, 32'd0);

    // collision: wb first, load next
    wb(5'd5, 32'hAAAA0000); lsu(5'd6, 32'h12345678);
    #1 chk("coll_lsu_blocked", 32'(lsu_ready), 32'd0);
    step(1);
    chk("coll_wb_wa3", 32'(wa3), 32'd5);
    chk("coll_wb_wd3", wd3, 32'hAAAA0000);
    wb_valid = 1'b0;
    #1 chk("coll_lsu_ready", 32'(lsu_ready), 32'd1);
    step(1);
    chk("coll_lsu_wa3", 32'(wa3), 32'd6);
    chk("coll_lsu_wd3", wd3, 32'h12345678);
    idle();
    step(1);
    chk("idle_wa3", 32'(wa3), 32'd0);
    chk("idle_wd3", wd3, 32'd0);

    // starvation
    wb(5'd10, 32'h1); lsu(5'd7, 32'h77);
    step(3);
    chk("starve_no_stall_yet", 32'(stall), 32'd0);
    step(1);
    chk("starve_stall_up", 32'(stall), 32'd1);
    chk("starve_wb_still", 32'(wa3), 32'd10);
    step(1);
    chk("starve_stall_down", 32'(stall), 32'd0);
    chk("starve_lsu_wa3", 32'(wa3), 32'd7);
    chk("starve_lsu_wd3", wd3, 32'h77);
    idle();
    step(1);

    // scoreboard
    iss(5'd9);
    step(1);
    chk("sb_set", 32'(pend_vec[9]), 32'd1);
    idle(); lsu(5'd9, 32'h99);
    step(1);
    chk("sb_clear", 32'(pend_vec[9]), 32'd0);
    chk("sb_ret_wa3", 32'(wa3), 32'd9);
    idle(); iss(5'd9);
    step(1);
    idle(); iss(5'd9); lsu(5'd9, 32'h98);
    step(1);
    chk("sb_set_wins", 32'(pend_vec[9]), 32'd1);
    chk("sb_same_wd3", wd3, 32'h98);
    idle(); lsu(5'd9, 32'h97);
    step(1);
    chk("sb_clear2", 32'(pend_vec[9]), 32'd0);

    // x0 writes
    idle(); wb(5'd0, 32'hFFFFFFFF); iss(5'd0);
    step(1);
    chk("x0_we3", 32'(we3), 32'd0);
    chk("x0_wa3", 32'(wa3), 32'd0);
    chk("x0_wd3", wd3, 32'd0);
    chk("x0_pend", 32'(pend_vec[0]), 32'd0);
    idle(); lsu(5'd0, 32'h5);
    step(1);
    chk("x0_lsu_we3", 32'(we3), 32'd0);
    idle();
    step(1);

`ifdef NF_DBG_WR_EN
    dbg_valid = 1'b1; dbg_rd = 5'd3; dbg_data = 32'hD3;
    #1 chk("dbg_ready", 32'(dbg_ready), 32'd1);
    step(1);
    chk("dbg_wa3", 32'(wa3), 32'd3);
    chk("dbg_wd3", wd3, 32'hD3);
    idle(); iss(5'd3);
    step(1);
    idle(); dbg_valid = 1'b1; dbg_rd = 5'd3; dbg_data = 32'h1;
    step(1);
    chk("dbg_keeps_pend", 32'(pend_vec[3]), 32'd1);
    wb(5'd8, 32'h8);
    #1 chk("dbg_blocked", 32'(dbg_ready), 32'd0);
    step(1);
    chk("dbg_lost_to_wb", 32'(wa3), 32'd8);
    idle(); lsu(5'd3, 32'h33);
    step(1);
    idle();
    step(1);
`endif

    // mid-run reset with a waiting load
    iss(5'd12);
    step(1);
    chk("mr_pend12", 32'(pend_vec[12]), 32'd1);
    idle(); wb(5'd1, 32'h1); lsu(5'd12, 32'hC);
    step(2);
    rst = 1'b1;
    step(1);
    chk("mr_busy", 32'(init_busy), 32'd1);
    chk("mr_pend", pend_vec, 32'd0);
    chk("mr_we3", 32'(we3), 32'd0);
    chk("mr_lsu_ready", 32'(lsu_ready), 32'd0);
    rst = 1'b0;
    idle();
    step(1);
    chk("mr_first_wa3", 32'(wa3), 32'd1);
    step(30);
    chk("mr_last_wa3", 32'(wa3), 32'd31);
    step(1);
    chk("mr_busy_low", 32'(init_busy), 32'd0);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
